// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-item vending controller.
// State encoding, its width, and price-table extraction live here.
package vend_pkg;

  localparam int STATE_W = 3;
  localparam int PRICE_MAX_W = 32;
  localparam int PRICE_TBL_W = 512;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_DISPENSE,
    ST_CHANGE,
    ST_REFUND
  } vend_state_t;

  // Extracts entry idx of a packed table whose entries are money_w bits wide.
  function automatic logic [PRICE_MAX_W-1:0] price_of(
    input logic [PRICE_TBL_W-1:0] prices,
    input int idx,
    input int money_w
  );
    logic [PRICE_MAX_W-1:0] p;
    logic [8:0] pos;
    p = '0;
    for (int b = 0; b < PRICE_MAX_W; b++) begin
      if (b < money_w && (idx * money_w + b) < PRICE_TBL_W) begin
        pos  = 9'(idx * money_w + b);
        p[b] = prices[pos];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter; done is high while the count is zero.
// Used for the dispense pulse length and the inactivity timeout.
module vend_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst)
      count_reg <= '0;
    else if (load)
      count_reg <= load_val;
    else if (en && count_reg != '0)
      count_reg <= count_reg - 1'b1;
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: credit, price lookup, timed dispense, change/refund, timeout.
// Optional per-item stock tracking is enabled by defining VEND_STOCK_TRACK_EN.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS = 4,
  parameter int MONEY_W = 8,
  parameter logic [NUM_ITEMS*MONEY_W-1:0] PRICES = {8'd20, 8'd3, 8'd10, 8'd5},
  parameter int MAX_CREDIT = 200,
  parameter int DISPENSE_CYC = 5,
  parameter int TIMEOUT_CYC = 1000
`ifdef VEND_STOCK_TRACK_EN
  ,
  parameter int STOCK_W = 4,
  parameter int STOCK_INIT = 10
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         cancel,
  input  logic                         coin_valid,
  input  logic [MONEY_W-1:0]           coin_val,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] sel_idx,
  input  logic                         change_ack,
`ifdef VEND_STOCK_TRACK_EN
  input  logic                         restock,
  output logic [NUM_ITEMS-1:0]         sold_out,
`endif
  output logic [MONEY_W-1:0]           credit,
  output logic                         busy,
  output logic                         coin_reject,
  output logic                         sel_reject,
  output logic                         dispense_valid,
  output logic [$clog2(NUM_ITEMS)-1:0] dispense_idx,
  output logic                         change_valid,
  output logic [MONEY_W-1:0]           change_amt
);

  localparam int IDX_W = $clog2(NUM_ITEMS);
  localparam int TBL_N = 2 ** IDX_W;
  localparam int DSP_W = $clog2(DISPENSE_CYC + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  vend_state_t state_reg, state_next;
  logic [MONEY_W-1:0] credit_reg, credit_next;
  logic [MONEY_W-1:0] change_amt_reg, change_amt_next;
  logic [IDX_W-1:0] dispense_idx_reg, dispense_idx_next;
  logic busy_reg, busy_next, dispense_valid_reg, dispense_valid_next;
  logic change_valid_reg, change_valid_next;
  logic coin_reject_reg, coin_reject_next, sel_reject_reg, sel_reject_next;
  logic sel_accept, dsp_load, dsp_done, to_load, to_en, to_done;

  // Table padded to a power of two so any sel_idx indexes safely; padding is never accepted.
  logic [MONEY_W-1:0] price_tbl [TBL_N];
  for (genvar gi = 0; gi < TBL_N; gi++) begin : g_price
    if (gi < NUM_ITEMS) begin : g_real
      assign price_tbl[gi] = MONEY_W'(price_of(PRICE_TBL_W'(PRICES), gi, MONEY_W));
    end else begin : g_pad
      assign price_tbl[gi] = '0;
    end
  end

  logic [MONEY_W:0] coin_sum;
  logic coin_fits, idx_in_range, stock_ok, sel_ok;
  assign coin_sum = {1'b0, credit_reg} + {1'b0, coin_val};
  assign coin_fits = coin_sum <= (MONEY_W+1)'(MAX_CREDIT);
  assign idx_in_range = {1'b0, sel_idx} < (IDX_W+1)'(NUM_ITEMS);
  assign sel_ok = idx_in_range && stock_ok && (credit_reg >= price_tbl[sel_idx]);

`ifdef VEND_STOCK_TRACK_EN
  logic [TBL_N-1:0] stock_nz;
  for (genvar gi = 0; gi < TBL_N; gi++) begin : g_stock
    if (gi < NUM_ITEMS) begin : g_item
      logic [STOCK_W-1:0] stock_reg, stock_next;
      logic sold_reg;
      always_comb begin
        stock_next = stock_reg;
        if (restock && state_reg == ST_IDLE)
          stock_next = STOCK_W'(STOCK_INIT);
        else if (sel_accept && sel_idx == IDX_W'(gi))
          stock_next = stock_reg - 1'b1;
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          stock_reg <= STOCK_W'(STOCK_INIT);
          sold_reg  <= 1'b0;
        end else begin
          stock_reg <= stock_next;
          sold_reg  <= (stock_next == '0);
        end
      end
      assign stock_nz[gi] = (stock_reg != '0);
      assign sold_out[gi] = sold_reg;
    end else begin : g_pad
      assign stock_nz[gi] = 1'b0;
    end
  end
  assign stock_ok = stock_nz[sel_idx];
`else
  assign stock_ok = 1'b1;
`endif

  vend_timer #(.W(DSP_W)) u_dsp_timer (
    .clk(clk), .rst(rst), .load(dsp_load), .load_val(DSP_W'(DISPENSE_CYC - 1)),
    .en(state_reg == ST_DISPENSE), .done(dsp_done)
  );

  vend_timer #(.W(TO_W)) u_to_timer (
    .clk(clk), .rst(rst), .load(to_load), .load_val(TO_W'(TIMEOUT_CYC - 1)),
    .en(to_en), .done(to_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= ST_IDLE;
      credit_reg         <= '0;
      busy_reg           <= 1'b0;
      coin_reject_reg    <= 1'b0;
      sel_reject_reg     <= 1'b0;
      dispense_valid_reg <= 1'b0;
      dispense_idx_reg   <= '0;
      change_valid_reg   <= 1'b0;
      change_amt_reg     <= '0;
    end else begin
      state_reg          <= state_next;
      credit_reg         <= credit_next;
      busy_reg           <= busy_next;
      coin_reject_reg    <= coin_reject_next;
      sel_reject_reg     <= sel_reject_next;
      dispense_valid_reg <= dispense_valid_next;
      dispense_idx_reg   <= dispense_idx_next;
      change_valid_reg   <= change_valid_next;
      change_amt_reg     <= change_amt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    credit_next      = credit_reg;
    coin_reject_next = 1'b0;
    sel_reject_next  = 1'b0;
    sel_accept       = 1'b0;
    dsp_load         = 1'b0;
    to_load          = 1'b0;
    to_en            = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next  = ST_CREDIT;
          credit_next = '0;
          to_load     = 1'b1;
        end
      end
      ST_CREDIT: begin
        if (cancel) begin
          state_next = (credit_reg != '0) ? ST_REFUND : ST_IDLE;
        end else begin
          if (coin_valid) begin
            if (coin_fits) begin
              credit_next = coin_sum[MONEY_W-1:0];
              to_load     = 1'b1;
            end else begin
              coin_reject_next = 1'b1;
            end
            if (sel_valid) begin
              sel_reject_next = 1'b1;
              to_load         = 1'b1;
            end
          end else if (sel_valid) begin
            to_load = 1'b1;
            if (sel_ok) begin
              state_next  = ST_DISPENSE;
              credit_next = credit_reg - price_tbl[sel_idx];
              dsp_load    = 1'b1;
              sel_accept  = 1'b1;
            end else begin
              sel_reject_next = 1'b1;
            end
          end
          // A cycle with no accepted coin and no selection attempt counts toward the timeout.
          if (!to_load) begin
            if (to_done)
              state_next = (credit_reg != '0) ? ST_REFUND : ST_IDLE;
            else
              to_en = 1'b1;
          end
        end
      end
      ST_DISPENSE: begin
        if (dsp_done)
          state_next = (credit_reg != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE, ST_REFUND: begin
        if (change_ack) begin
          state_next  = ST_IDLE;
          credit_next = '0;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        credit_next = '0;
      end
    endcase
  end

  always_comb begin
    busy_next           = (state_next != ST_IDLE);
    dispense_valid_next = (state_next == ST_DISPENSE);
    dispense_idx_next   = '0;
    if (sel_accept)
      dispense_idx_next = sel_idx;
    else if (state_next == ST_DISPENSE)
      dispense_idx_next = dispense_idx_reg;
    change_valid_next = (state_next == ST_CHANGE) || (state_next == ST_REFUND);
    change_amt_next   = change_valid_next ? credit_next : '0;
  end

  assign credit         = credit_reg;
  assign busy           = busy_reg;
  assign coin_reject    = coin_reject_reg;
  assign sel_reject     = sel_reject_reg;
  assign dispense_valid = dispense_valid_reg;
  assign dispense_idx   = dispense_idx_reg;
  assign change_valid   = change_valid_reg;
  assign change_amt     = change_amt_reg;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi with hand-computed expectations.
// Stock-tracking checks run only when VEND_STOCK_TRACK_EN is defined.
module tb_vend_ctrl_multi;

  logic clk = 1'b0;
  logic rst, start, cancel, coin_valid, sel_valid, change_ack;
  logic [7:0] coin_val;
  logic [1:0] sel_idx;
  logic [7:0] credit, change_amt;
  logic busy, coin_reject, sel_reject, dispense_valid, change_valid;
  logic [1:0] dispense_idx;
`ifdef VEND_STOCK_TRACK_EN
  logic restock;
  logic [3:0] sold_out;
`endif

  int n_checks = 0;
  int n_errors = 0;

  vend_ctrl_multi dut (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel),
    .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .change_ack(change_ack),
`ifdef VEND_STOCK_TRACK_EN
    .restock(restock), .sold_out(sold_out),
`endif
    .credit(credit), .busy(busy), .coin_reject(coin_reject), .sel_reject(sel_reject),
    .dispense_valid(dispense_valid), .dispense_idx(dispense_idx),
    .change_valid(change_valid), .change_amt(change_amt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic st, input logic ca, input logic cv, input int cval,
                      input logic sv, input int si, input logic ack);
    start = st; cancel = ca; coin_valid = cv; coin_val = 8'(cval);
    sel_valid = sv; sel_idx = 2'(si); change_ack = ack;
    tick();
    start = 0; cancel = 0; coin_valid = 0; coin_val = 0;
    sel_valid = 0; sel_idx = 0; change_ack = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_start();  step(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_cancel(); step(0, 1, 0, 0, 0, 0, 0); endtask
  task automatic do_ack();    step(0, 0, 0, 0, 0, 0, 1); endtask
  task automatic coin(input int v); step(0, 0, 1, v, 0, 0, 0); endtask
  task automatic sel(input int i);  step(0, 0, 0, 0, 1, i, 0); endtask

  // Counts consecutive samples with dispense_valid high, bounded.
  task automatic wait_dispense(output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (!dispense_valid) break;
      n++;
      idle(1);
    end
  endtask

  int n;
  logic cv_seen;

  initial begin
    rst = 1; start = 0; cancel = 0; coin_valid = 0; coin_val = 0;
    sel_valid = 0; sel_idx = 0; change_ack = 0;
`ifdef VEND_STOCK_TRACK_EN
    restock = 0;
`endif
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_credit", credit, 0);
    check("rst_dispense", dispense_valid, 0);
    check("rst_change", change_valid, 0);
    rst = 0;

    coin(20);
    check("idle_coin_ignored", credit, 0);
    check("idle_busy", busy, 0);

    // Coin 20, buy item 1 (price 10), change 10.
    do_start();
    check("t1_busy", busy, 1);
    check("t1_credit0", credit, 0);
    coin(20);
    check("t1_credit", credit, 20);
    sel(1);
    check("t1_disp_valid", dispense_valid, 1);
    check("t1_disp_idx", dispense_idx, 1);
    check("t1_credit_after", credit, 10);
    wait_dispense(n);
    check("t1_disp_len", n, 5);
    check("t1_change_valid", change_valid, 1);
    check("t1_change_amt", change_amt, 10);
    idle(3);
    check("t1_change_wait", change_valid, 1);
    check("t1_change_amt_hold", change_amt, 10);
    do_ack();
    check("t1_ack_change", change_valid, 0);
    check("t1_ack_credit", credit, 0);
    check("t1_ack_busy", busy, 0);

    // Coins 2,2,2 then item 0 (price 5), change 1.
    do_start();
    coin(2); coin(2); coin(2);
    check("t2_credit", credit, 6);
    sel(0);
    check("t2_disp_idx", dispense_idx, 0);
    check("t2_credit_after", credit, 1);
    wait_dispense(n);
    check("t2_disp_len", n, 5);
    check("t2_change_amt", change_amt, 1);
    do_ack();
    check("t2_busy", busy, 0);

    // Insufficient credit, then cancel refund.
    do_start();
    coin(2);
    sel(1);
    check("t3_sel_reject", sel_reject, 1);
    check("t3_credit", credit, 2);
    check("t3_no_disp", dispense_valid, 0);
    idle(1);
    check("t3_sel_reject_pulse", sel_reject, 0);
    do_cancel();
    check("t3_refund_valid", change_valid, 1);
    check("t3_refund_amt", change_amt, 2);
    do_ack();
    check("t3_busy", busy, 0);

    // Coin and select together, then fill to MAX_CREDIT.
    do_start();
    step(0, 0, 1, 20, 1, 1, 0);
    check("t4_cs_credit", credit, 20);
    check("t4_cs_sel_reject", sel_reject, 1);
    check("t4_cs_no_disp", dispense_valid, 0);
    repeat (9) coin(20);
    check("t4_credit_max", credit, 200);
    check("t4_no_coin_reject", coin_reject, 0);
    coin(20);
    check("t4_coin_reject", coin_reject, 1);
    check("t4_credit_held", credit, 200);
    idle(1);
    check("t4_coin_reject_pulse", coin_reject, 0);
    do_cancel();
    check("t4_refund_amt", change_amt, 200);
    do_ack();

    // Inactivity timeout with credit -> refund.
    do_start();
    coin(2);
    idle(999);
    check("t5_before_timeout", change_valid, 0);
    check("t5_busy_before", busy, 1);
    idle(1);
    check("t5_timeout_refund", change_valid, 1);
    check("t5_timeout_amt", change_amt, 2);
    do_ack();

    // Inactivity timeout without credit -> idle, no refund.
    do_start();
    cv_seen = 0;
    for (int i = 0; i < 999; i++) begin
      idle(1);
      if (change_valid) cv_seen = 1;
    end
    check("t5b_busy_before", busy, 1);
    idle(1);
    if (change_valid) cv_seen = 1;
    check("t5b_idle_after", busy, 0);
    check("t5b_no_change", cv_seen, 0);

    // Reset in the second dispense cycle.
    do_start();
    coin(20);
    sel(1);
    idle(1);
    check("t6_disp_cycle2", dispense_valid, 1);
    rst = 1;
    tick();
    rst = 0;
    check("t6_rst_disp", dispense_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_credit", credit, 0);
    check("t6_rst_change", change_valid, 0);
    idle(1);
    check("t6_still_idle", busy, 0);

`ifdef VEND_STOCK_TRACK_EN
    // Sell out item 3 (price 20).
    for (int k = 0; k < 10; k++) begin
      do_start();
      coin(20);
      sel(3);
      wait_dispense(n);
    end
    check("t7_sold_out", sold_out, 8);
    check("t7_idle", busy, 0);
    do_start();
    coin(20);
    sel(3);
    check("t7_sel_reject", sel_reject, 1);
    check("t7_no_disp", dispense_valid, 0);
    check("t7_credit", credit, 20);
    do_cancel();
    do_ack();
    restock = 1;
    tick();
    restock = 0;
    check("t7_restock", sold_out, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
